// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state codes, default device ID, bit-counter sizing.
// Imported by both the SCCB responder and the SCCB master.
package sccb_pkg;

    localparam logic [7:0] SCCB_DEV_ID = 8'h42;
    localparam int         BIT_CNT_W   = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = 4'd8;

    typedef logic [2:0] sccb_state_t;

    localparam sccb_state_t ST_IDLE      = 3'd0;
    localparam sccb_state_t ST_ID        = 3'd1;
    localparam sccb_state_t ST_SUB       = 3'd2;
    localparam sccb_state_t ST_WDAT      = 3'd3;
    localparam sccb_state_t ST_RDAT      = 3'd4;
    localparam sccb_state_t ST_WAIT_STOP = 3'd5;

    function automatic logic [7:0] sccb_read_id(input logic [7:0] write_id);
        return write_id | 8'h01;
    endfunction

endpackage

// File: rtl/sccb_slave_sync.sv
// Brings the asynchronous SCCB pins into the clk domain and produces registered
// edge and start/stop events together with the SDA level aligned to them.
module sccb_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic scl_hist_q;
    logic sda_hist_q;
    logic scl_rise_q;
    logic scl_fall_q;
    logic start_q;
    logic stop_q;
    logic sda_q;
    logic scl_now;
    logic sda_now;

    assign scl_now = scl_sync_q[SYNC_STAGES-1];
    assign sda_now = sda_sync_q[SYNC_STAGES-1];

    // Idle bus is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_q      <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_now;
            sda_hist_q <= sda_now;
            scl_rise_q <= scl_now & ~scl_hist_q;
            scl_fall_q <= ~scl_now & scl_hist_q;
            start_q    <= scl_now & scl_hist_q & sda_hist_q & ~sda_now;
            stop_q     <= scl_now & scl_hist_q & ~sda_hist_q & sda_now;
            sda_q      <= sda_now;
        end
    end

    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign sda_o      = sda_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: decodes ID / sub-address / data phases from the bus and turns
// them into single-cycle register-file write strobes and read requests.
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = SCCB_DEV_ID,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_out_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_rise, scl_fall, bus_start, bus_stop, sda_bit;

    sccb_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (sclk),
        .sda_i      (sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop),
        .sda_o      (sda_bit)
    );

    sccb_state_t            state_q, state_d;
    logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   out_q, out_d;
    logic                   out_en_q, out_en_d;
    logic                   busy_q, busy_d;

    // Bus start/stop outrank clock edges; the byte's ninth (X/NA) bit closes each phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        rd_pend_d = rd_q;
        out_d     = out_q;
        out_en_d  = out_en_q;
        busy_d    = busy_q;

        if (rd_pend_q) begin
            tx_d = reg_rdata;
        end

        if (bus_stop) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            busy_d   = 1'b0;
            out_d    = 1'b1;
            out_en_d = 1'b0;
        end else if (bus_start) begin
            state_d  = ST_ID;
            cnt_d    = '0;
            busy_d   = 1'b1;
            out_d    = 1'b1;
            out_en_d = 1'b0;
        end else if ((state_q == ST_ID || state_q == ST_SUB || state_q == ST_WDAT) && scl_rise) begin
            if (cnt_q != LAST_BIT) begin
                shift_d = {shift_q[6:0], sda_bit};
                cnt_d   = cnt_q + 4'd1;
            end else begin
                cnt_d = '0;
                if (state_q == ST_ID) begin
                    if (shift_q == DEV_ID) begin
                        state_d = ST_SUB;
                    end else if (shift_q == sccb_read_id(DEV_ID)) begin
                        state_d = ST_RDAT;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = ST_WAIT_STOP;
                    end
                end else if (state_q == ST_SUB) begin
                    addr_d  = shift_q;
                    state_d = ST_WDAT;
                end else begin
                    wdata_d = shift_q;
                    wr_d    = 1'b1;
                    state_d = ST_WAIT_STOP;
                end
            end
        end else if (state_q == ST_RDAT && scl_fall) begin
            if (cnt_q != LAST_BIT) begin
                out_d    = tx_q[7];
                tx_d     = {tx_q[6:0], 1'b0};
                out_en_d = 1'b1;
                cnt_d    = cnt_q + 4'd1;
            end else begin
                out_d    = 1'b1;
                out_en_d = 1'b0;
                cnt_d    = '0;
                state_d  = ST_WAIT_STOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            out_q     <= 1'b1;
            out_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rd_pend_q <= rd_pend_d;
            out_q     <= out_d;
            out_en_q  <= out_en_d;
            busy_q    <= busy_d;
        end
    end

    assign sda_out    = out_q;
    assign sda_out_en = out_en_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_wr     = wr_q;
    assign reg_rd     = rd_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: plays the SCCB master on the bus, hosts a camera register
// file behind the register port, and checks against an array-based expected model.
module tb_sccb_slave;
    import sccb_pkg::*;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       masterScl = 1'b1;
    logic       masterSda = 1'b1;
    logic       sdaBus;
    logic       sda_out, sda_out_en, reg_wr, reg_rd, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    assign sdaBus = masterSda & (sda_out_en ? sda_out : 1'b1);

    sccb_slave #(.DEV_ID(8'h42), .SYNC_STAGES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (masterScl),
        .sda_in     (sdaBus),
        .sda_out    (sda_out),
        .sda_out_en (sda_out_en),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Camera register file contents before any write
    function automatic logic [7:0] initVal(input logic [7:0] a);
        return a ^ 8'hAF;
    endfunction

    bit [7:0]   regMem [256];
    bit         regWritten [256];
    int         wrCount = 0;
    int         rdCount = 0;
    int         enCycles = 0;
    logic [7:0] lastWrAddr = 8'h00;
    logic [7:0] lastWrData = 8'h00;
    logic [7:0] lastRdAddr = 8'h00;

    assign reg_rdata = regWritten[reg_addr] ? regMem[reg_addr] : initVal(reg_addr);

    always @(negedge clk) begin
        if (reg_wr) begin
            wrCount++;
            lastWrAddr = reg_addr;
            lastWrData = reg_wdata;
            regMem[reg_addr] = reg_wdata;
            regWritten[reg_addr] = 1'b1;
        end
        if (reg_rd) begin
            rdCount++;
            lastRdAddr = reg_addr;
        end
        if (sda_out_en) enCycles++;
    end

    logic [7:0] model [256];
    int testsRun = 0;
    int failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitQ(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic sendStart();
        masterSda = 1'b1;
        waitQ(1);
        masterScl = 1'b1;
        waitQ(1);
        masterSda = 1'b0;
        waitQ(1);
        masterScl = 1'b0;
        waitQ(1);
    endtask

    task automatic sendStop();
        masterSda = 1'b0;
        waitQ(1);
        masterScl = 1'b1;
        waitQ(1);
        masterSda = 1'b1;
        waitQ(2);
    endtask

    task automatic sendBit(input logic b);
        masterSda = b;
        waitQ(1);
        masterScl = 1'b1;
        waitQ(2);
        masterScl = 1'b0;
        waitQ(1);
    endtask

    task automatic readBit(output logic b, output logic en);
        masterSda = 1'b1;
        waitQ(1);
        masterScl = 1'b1;
        waitQ(1);
        b  = sdaBus;
        en = sda_out_en;
        waitQ(1);
        masterScl = 1'b0;
        waitQ(1);
    endtask

    task automatic sendByte(input logic [7:0] value);
        for (int i = 7; i >= 0; i--) sendBit(value[i]);
        sendBit(1'b1);
    endtask

    task automatic readByte(output logic [7:0] value, output int enBits, output logic naEn);
        logic b, en;
        value  = 8'h00;
        enBits = 0;
        for (int i = 0; i < 8; i++) begin
            readBit(b, en);
            value = {value[6:0], b};
            if (en) enBits++;
        end
        readBit(b, naEn);
    endtask

    // kind 0: 3-phase write, 1: 2-phase write then read, 2: sub-address then repeated-start read
    task automatic applyStimulus(input int kind, input logic [7:0] id, input logic [7:0] addr,
                                 input logic [7:0] data, output logic [7:0] rdata,
                                 output int enBits, output logic naEn);
        rdata  = 8'h00;
        enBits = 0;
        naEn   = 1'b0;
        sendStart();
        sendByte(id);
        sendByte(addr);
        if (kind == 0) begin
            sendByte(data);
        end else begin
            if (kind == 1) begin
                sendStop();
            end
            sendStart();
            sendByte(id | 8'h01);
            readByte(rdata, enBits, naEn);
        end
        sendStop();
        waitQ(1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         w0, r0, e0, enBits, kind;
        logic [7:0] rdata, addr, data;
        logic       naEn, b, en;

        for (int i = 0; i < 256; i++) model[i] = initVal(8'(i));

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_sda_out", sda_out, 1);
        checkOutput("reset_sda_out_en", sda_out_en, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_reg_addr", reg_addr, 0);
        checkOutput("reset_reg_wdata", reg_wdata, 0);
        checkOutput("reset_reg_wr", reg_wr, 0);
        checkOutput("reset_reg_rd", reg_rd, 0);

        $display("[TB] write 12 <= 80");
        w0 = wrCount; r0 = rdCount; e0 = enCycles;
        sendStart();
        checkOutput("w1_busy_after_start", busy, 1);
        sendByte(8'h42);
        sendByte(8'h12);
        sendByte(8'h80);
        sendStop();
        waitQ(1);
        model[8'h12] = 8'h80;
        checkOutput("w1_wr_count", wrCount - w0, 1);
        checkOutput("w1_rd_count", rdCount - r0, 0);
        checkOutput("w1_addr", lastWrAddr, 8'h12);
        checkOutput("w1_data", lastWrData, 8'h80);
        checkOutput("w1_en_cycles", enCycles - e0, 0);
        checkOutput("w1_busy_after_stop", busy, 0);

        $display("[TB] 2-phase write 0A then read");
        w0 = wrCount; r0 = rdCount;
        applyStimulus(1, 8'h42, 8'h0A, 8'h00, rdata, enBits, naEn);
        checkOutput("r1_wr_count", wrCount - w0, 0);
        checkOutput("r1_rd_count", rdCount - r0, 1);
        checkOutput("r1_rd_addr", lastRdAddr, 8'h0A);
        checkOutput("r1_rdata", rdata, model[8'h0A]);
        checkOutput("r1_en_bits", enBits, 8);
        checkOutput("r1_na_released", naEn, 0);
        checkOutput("r1_busy", busy, 0);

        $display("[TB] foreign ID 60");
        w0 = wrCount; r0 = rdCount; e0 = enCycles;
        applyStimulus(0, 8'h60, 8'h12, 8'h34, rdata, enBits, naEn);
        checkOutput("id60_wr_count", wrCount - w0, 0);
        checkOutput("id60_rd_count", rdCount - r0, 0);
        checkOutput("id60_en_cycles", enCycles - e0, 0);
        checkOutput("id60_busy", busy, 0);

        $display("[TB] reset during read bit 3");
        sendStart();
        sendByte(8'h43);
        for (int i = 0; i < 3; i++) readBit(b, en);
        masterSda = 1'b1;
        waitQ(1);
        masterScl = 1'b1;
        waitQ(1);
        checkOutput("rst_en_before", sda_out_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_sda_out_en", sda_out_en, 0);
        checkOutput("rst_sda_out", sda_out, 1);
        checkOutput("rst_busy", busy, 0);
        waitQ(1);
        masterScl = 1'b0;
        waitQ(1);
        sendStop();
        w0 = wrCount;
        applyStimulus(0, 8'h42, 8'h34, 8'h56, rdata, enBits, naEn);
        model[8'h34] = 8'h56;
        checkOutput("rst_w_count", wrCount - w0, 1);
        checkOutput("rst_w_addr", lastWrAddr, 8'h34);
        checkOutput("rst_w_data", lastWrData, 8'h56);

        $display("[TB] repeated start after SUB");
        w0 = wrCount; r0 = rdCount;
        applyStimulus(2, 8'h42, 8'h21, 8'h00, rdata, enBits, naEn);
        checkOutput("rs_wr_count", wrCount - w0, 0);
        checkOutput("rs_rd_count", rdCount - r0, 1);
        checkOutput("rs_rd_addr", lastRdAddr, 8'h21);
        checkOutput("rs_rdata", rdata, model[8'h21]);

        $display("[TB] random transfers");
        for (int t = 0; t < 16; t++) begin
            kind = int'($urandom_range(0, 1));
            addr = 8'($urandom_range(8'h40, 8'h47));
            data = 8'($urandom);
            w0 = wrCount; r0 = rdCount;
            applyStimulus(kind, 8'h42, addr, data, rdata, enBits, naEn);
            if (kind == 0) begin
                model[addr] = data;
                checkOutput("rnd_wr_count", wrCount - w0, 1);
                checkOutput("rnd_wr_addr", lastWrAddr, addr);
                checkOutput("rnd_wr_data", lastWrData, data);
            end else begin
                checkOutput("rnd_rd_count", rdCount - r0, 1);
                checkOutput("rnd_rdata", rdata, model[addr]);
                checkOutput("rnd_en_bits", enBits, 8);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
